// File: rtl/finalproject_soc_ram_arbiter_if.sv
// Bus bundle between the two RAM requesters, the RAM arbiter and the single-port RAM.
// The arbiter takes the slave side; requesters and RAM together take the master side.
interface finalproject_soc_ram_arbiter_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] a_address;
    logic [BE_W-1:0]   a_byteenable;
    logic              a_read;
    logic              a_write;
    logic [DATA_W-1:0] a_writedata;
    logic              a_waitrequest;
    logic              a_readdatavalid;
    logic [DATA_W-1:0] a_readdata;

    logic [ADDR_W-1:0] b_address;
    logic [BE_W-1:0]   b_byteenable;
    logic              b_read;
    logic              b_write;
    logic [DATA_W-1:0] b_writedata;
    logic              b_waitrequest;
    logic              b_readdatavalid;
    logic [DATA_W-1:0] b_readdata;

    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;

    logic              busy;

    modport slave (
        input  a_address, a_byteenable, a_read, a_write, a_writedata,
        output a_waitrequest, a_readdatavalid, a_readdata,
        input  b_address, b_byteenable, b_read, b_write, b_writedata,
        output b_waitrequest, b_readdatavalid, b_readdata,
        output mem_address, mem_byteenable, mem_chipselect, mem_write,
        output mem_writedata, mem_clken,
        input  mem_readdata,
        output busy
    );

    modport master (
        output a_address, a_byteenable, a_read, a_write, a_writedata,
        input  a_waitrequest, a_readdatavalid, a_readdata,
        output b_address, b_byteenable, b_read, b_write, b_writedata,
        input  b_waitrequest, b_readdatavalid, b_readdata,
        input  mem_address, mem_byteenable, mem_chipselect, mem_write,
        input  mem_writedata, mem_clken,
        output mem_readdata,
        input  busy
    );
endinterface

// File: rtl/finalproject_soc_ram_arbiter.sv
// Round-robin arbiter for the shared on-chip RAM: zero-fills the RAM after reset,
// then grants one transaction per cycle to requester A or B and routes read valids back.
module finalproject_soc_ram_arbiter #(
    parameter int ADDR_W         = 2,
    parameter int DATA_W         = 32,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic clk,
    input  logic reset,
    finalproject_soc_ram_arbiter_if.slave bus
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    localparam state_t            RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
    localparam logic [ADDR_W-1:0] LAST_ADDR   = '1;
    localparam logic              GRANT_A     = 1'b0;
    localparam logic              GRANT_B     = 1'b1;

    state_t            r_state;
    state_t            w_nextState;
    logic [ADDR_W-1:0] r_clrCnt;
    logic              r_lastGrant;
    logic              r_rdvA;
    logic              r_rdvB;

    logic w_aActive;
    logic w_bActive;
    logic w_aRead;
    logic w_bRead;
    logic w_grantA;
    logic w_grantB;

    // Read+write together counts as a write, so only a pure read earns a valid pulse
    assign w_aActive = bus.a_read | bus.a_write;
    assign w_bActive = bus.b_read | bus.b_write;
    assign w_aRead   = bus.a_read & ~bus.a_write;
    assign w_bRead   = bus.b_read & ~bus.b_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RESET_STATE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clrCnt    <= '0;
            r_lastGrant <= GRANT_B;
            r_rdvA      <= 1'b0;
            r_rdvB      <= 1'b0;
        end else begin
            if (r_state == ST_CLEAR) begin
                r_clrCnt <= r_clrCnt + 1'b1;
            end
            if (w_grantA) begin
                r_lastGrant <= GRANT_A;
            end else if (w_grantB) begin
                r_lastGrant <= GRANT_B;
            end
            r_rdvA <= w_grantA & w_aRead;
            r_rdvB <= w_grantB & w_bRead;
        end
    end

    // Everything is held quiet while reset is high, since the reset is only seen at the edge
    always_comb begin
        w_nextState        = r_state;
        w_grantA           = 1'b0;
        w_grantB           = 1'b0;
        bus.a_waitrequest  = 1'b1;
        bus.b_waitrequest  = 1'b1;
        bus.mem_chipselect = 1'b0;
        bus.mem_write      = 1'b0;
        bus.mem_address    = '0;
        bus.mem_byteenable = '0;
        bus.mem_writedata  = '0;
        bus.busy           = 1'b0;

        if (!reset) begin
            case (r_state)
                ST_CLEAR: begin
                    bus.busy           = 1'b1;
                    bus.mem_chipselect = 1'b1;
                    bus.mem_write      = 1'b1;
                    bus.mem_address    = r_clrCnt;
                    bus.mem_byteenable = {BE_W{1'b1}};
                    bus.mem_writedata  = '0;
                    if (r_clrCnt == LAST_ADDR) begin
                        w_nextState = ST_RUN;
                    end
                end
                ST_RUN: begin
                    w_grantA = w_aActive & (~w_bActive | (r_lastGrant == GRANT_B));
                    w_grantB = w_bActive & (~w_aActive | (r_lastGrant == GRANT_A));
                    if (w_grantA) begin
                        bus.a_waitrequest  = 1'b0;
                        bus.mem_chipselect = 1'b1;
                        bus.mem_write      = bus.a_write;
                        bus.mem_address    = bus.a_address;
                        bus.mem_byteenable = bus.a_byteenable;
                        bus.mem_writedata  = bus.a_writedata;
                    end else if (w_grantB) begin
                        bus.b_waitrequest  = 1'b0;
                        bus.mem_chipselect = 1'b1;
                        bus.mem_write      = bus.b_write;
                        bus.mem_address    = bus.b_address;
                        bus.mem_byteenable = bus.b_byteenable;
                        bus.mem_writedata  = bus.b_writedata;
                    end
                end
                default: begin
                    w_nextState = RESET_STATE;
                end
            endcase
        end
    end

    assign bus.a_readdatavalid = r_rdvA & ~reset;
    assign bus.b_readdatavalid = r_rdvB & ~reset;
    assign bus.a_readdata      = bus.mem_readdata;
    assign bus.b_readdata      = bus.mem_readdata;
    assign bus.mem_clken       = 1'b1;
endmodule

// File: tb/tb_finalproject_soc_ram_arbiter.sv
// Self-checking bench for the RAM arbiter: models the RAM, drives both requesters and
// scores every read return against expectations queued at acceptance time.
module tb_finalproject_soc_ram_arbiter;
    localparam int ADDR_W = 2;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    finalproject_soc_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    finalproject_soc_ram_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // RAM model: byte-enabled writes, one-cycle registered read
    logic [31:0] ram [4];
    logic [31:0] ramQ;

    initial begin
        for (int i = 0; i < 4; i++) ram[i] = 32'hFFFF_FFFF;
        ramQ = 32'h0;
    end

    always @(posedge clk) begin
        if (bus.mem_chipselect === 1'b1) begin
            if (bus.mem_write === 1'b1) begin
                for (int i = 0; i < 4; i++) begin
                    if (bus.mem_byteenable[i]) ram[bus.mem_address][8*i +: 8] <= bus.mem_writedata[8*i +: 8];
                end
            end else begin
                ramQ <= ram[bus.mem_address];
            end
        end
    end

    assign bus.mem_readdata = ramQ;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t qA[$];
    exp_t qB[$];
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    logic [31:0] aExp = 32'h0;
    logic [31:0] bExp = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Each read return must match the oldest queued expectation, in the cycle it was promised
    always @(negedge clk) begin
        exp_t e;
        if (bus.a_readdatavalid === 1'b1) begin
            if (qA.size() == 0) begin
                checkOutput("a_rdv_unexpected", 32'(bus.a_readdatavalid), 32'h0);
            end else begin
                e = qA.pop_front();
                checkOutput("a_rdata", bus.a_readdata, e.data);
                checkOutput("a_rdv_cycle", cyc, e.cyc);
            end
        end else if (qA.size() != 0 && qA[0].cyc <= cyc) begin
            e = qA.pop_front();
            checkOutput("a_rdv_missing", 32'(bus.a_readdatavalid), 32'h1);
        end
        if (bus.b_readdatavalid === 1'b1) begin
            if (qB.size() == 0) begin
                checkOutput("b_rdv_unexpected", 32'(bus.b_readdatavalid), 32'h0);
            end else begin
                e = qB.pop_front();
                checkOutput("b_rdata", bus.b_readdata, e.data);
                checkOutput("b_rdv_cycle", cyc, e.cyc);
            end
        end else if (qB.size() != 0 && qB[0].cyc <= cyc) begin
            e = qB.pop_front();
            checkOutput("b_rdv_missing", 32'(bus.b_readdatavalid), 32'h1);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic setA(input logic rd, input logic wr, input logic [1:0] addr, input logic [3:0] be,
                        input logic [31:0] data, input logic [31:0] expData);
        bus.a_read = rd; bus.a_write = wr; bus.a_address = addr;
        bus.a_byteenable = be; bus.a_writedata = data; aExp = expData;
    endtask

    task automatic setB(input logic rd, input logic wr, input logic [1:0] addr, input logic [3:0] be,
                        input logic [31:0] data, input logic [31:0] expData);
        bus.b_read = rd; bus.b_write = wr; bus.b_address = addr;
        bus.b_byteenable = be; bus.b_writedata = data; bExp = expData;
    endtask

    // One bus cycle: sample acceptance mid-cycle, queue expected read data, end just after the edge
    task automatic stepCycle(output logic aAcc, output logic bAcc);
        @(negedge clk);
        aAcc = (bus.a_read | bus.a_write) & (bus.a_waitrequest === 1'b0);
        bAcc = (bus.b_read | bus.b_write) & (bus.b_waitrequest === 1'b0);
        if (aAcc && bus.a_read && !bus.a_write) qA.push_back('{data: aExp, cyc: cyc + 1});
        if (bAcc && bus.b_read && !bus.b_write) qB.push_back('{data: bExp, cyc: cyc + 1});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic aAcc, bAcc;
        repeat (n) stepCycle(aAcc, bAcc);
    endtask

    // Holds one request until accepted (bounded) and checks how long it waited
    task automatic applyStimulus(input bit useA, input logic rd, input logic wr, input logic [1:0] addr,
                                 input logic [3:0] be, input logic [31:0] data,
                                 input logic [31:0] expData, input int expWait);
        int waits;
        logic aAcc, bAcc, acc;
        string tag;
        waits = 0;
        acc = 1'b0;
        tag = useA ? "a_accept_wait" : "b_accept_wait";
        if (useA) setA(rd, wr, addr, be, data, expData);
        else      setB(rd, wr, addr, be, data, expData);
        while (!acc && waits < 8) begin
            stepCycle(aAcc, bAcc);
            acc = useA ? aAcc : bAcc;
            if (!acc) waits++;
        end
        checkOutput(tag, waits, expWait);
        if (useA) setA(0, 0, 0, 0, 0, 0);
        else      setB(0, 0, 0, 0, 0, 0);
    endtask

    // Called just after reset release: four zero-fill writes, then busy drops
    task automatic checkClear();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("clr_busy", 32'(bus.busy), 32'h1);
            checkOutput("clr_cs", 32'(bus.mem_chipselect), 32'h1);
            checkOutput("clr_write", 32'(bus.mem_write), 32'h1);
            checkOutput("clr_addr", 32'(bus.mem_address), i);
            checkOutput("clr_be", 32'(bus.mem_byteenable), 32'hF);
            checkOutput("clr_data", bus.mem_writedata, 32'h0);
            checkOutput("clr_a_wait", 32'(bus.a_waitrequest), 32'h1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput("clr_done_busy", 32'(bus.busy), 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic aAcc, bAcc;
        int nA, nB;
        setA(1, 0, 2, 4'hF, 0, 0);
        setB(0, 0, 0, 0, 0, 0);
        reset = 1'b1;

        @(negedge clk);
        checkOutput("rst_a_wait", 32'(bus.a_waitrequest), 32'h1);
        checkOutput("rst_b_wait", 32'(bus.b_waitrequest), 32'h1);
        checkOutput("rst_a_rdv", 32'(bus.a_readdatavalid), 32'h0);
        checkOutput("rst_b_rdv", 32'(bus.b_readdatavalid), 32'h0);
        checkOutput("rst_cs", 32'(bus.mem_chipselect), 32'h0);
        checkOutput("rst_write", 32'(bus.mem_write), 32'h0);
        checkOutput("rst_busy", 32'(bus.busy), 32'h0);
        @(posedge clk);
        #1;
        setA(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        checkClear();

        $display("[TB] read of cleared address");
        applyStimulus(1, 1, 0, 2, 4'hF, 0, 32'h0, 0);
        idle(1);

        $display("[TB] uncontended byte-enabled write then read");
        applyStimulus(1, 0, 1, 1, 4'b0101, 32'hDEADBEEF, 0, 0);
        applyStimulus(0, 1, 0, 1, 4'hF, 0, 32'h00AD00EF, 0);
        @(negedge clk);
        checkOutput("a_rdv_quiet", 32'(bus.a_readdatavalid), 32'h0);
        @(posedge clk);
        #1;

        $display("[TB] simultaneous reads after reset");
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkClear();
        setA(1, 0, 1, 4'hF, 0, 32'h0);
        setB(1, 0, 3, 4'hF, 0, 32'h0);
        stepCycle(aAcc, bAcc);
        checkOutput("sim_a_first", 32'(aAcc), 32'h1);
        checkOutput("sim_b_held", 32'(bAcc), 32'h0);
        setA(0, 0, 0, 0, 0, 0);
        stepCycle(aAcc, bAcc);
        checkOutput("sim_b_second", 32'(bAcc), 32'h1);
        setB(0, 0, 0, 0, 0, 0);
        idle(2);

        $display("[TB] continuous write contention");
        setA(0, 1, 0, 4'hF, 32'hAAAA5555, 0);
        setB(0, 1, 2, 4'hF, 32'hBBBB6666, 0);
        nA = 0;
        nB = 0;
        for (int i = 0; i < 10; i++) begin
            stepCycle(aAcc, bAcc);
            checkOutput("alt_a", 32'(aAcc), 32'(i % 2 == 0));
            checkOutput("alt_b", 32'(bAcc), 32'(i % 2 == 1));
            if (aAcc) nA++;
            if (bAcc) nB++;
        end
        checkOutput("alt_count_a", nA, 5);
        checkOutput("alt_count_b", nB, 5);
        setA(0, 0, 0, 0, 0, 0);
        setB(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 4'hF, 0, 32'hAAAA5555, 0);
        applyStimulus(0, 1, 0, 2, 4'hF, 0, 32'hBBBB6666, 0);
        idle(1);

        $display("[TB] read+write together behaves as write");
        applyStimulus(0, 1, 1, 3, 4'hF, 32'h12345678, 0, 0);
        @(negedge clk);
        checkOutput("rw_b_rdv", 32'(bus.b_readdatavalid), 32'h0);
        @(posedge clk);
        #1;
        applyStimulus(1, 1, 0, 3, 4'hF, 0, 32'h12345678, 0);
        idle(1);

        $display("[TB] reset during a read");
        setA(1, 0, 0, 4'hF, 0, 0);
        @(negedge clk);
        checkOutput("mr_accept", 32'(bus.a_waitrequest), 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        setA(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("mr_a_rdv", 32'(bus.a_readdatavalid), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkClear();
        idle(2);

        checkOutput("qA_drained", qA.size(), 0);
        checkOutput("qB_drained", qB.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
